tlp_tx_arbiter: RTL and testbench
=================================

Name: tlp_tx_arbiter

Overview:
- Packet-level arbiter that shares the single PCIe TX stream (txData/txValid/txReady/txSOP/txEOP) between NUM_SRC TLP producers, e.g. tlp_send completions, DMA write engine, MSI generator.
- Grants one source per TLP and holds the grant from SOP to EOP, so TLPs never interleave.
- Default scheduling is round-robin.
- Sits between the TLP producers and the hard IP TX interface.

Parameters:
- NUM_SRC, 3, number of requesting sources (2..8).
- SRC_BITS, $clog2(NUM_SRC), width of grant index.

Ports:
- pcieClk_in  in  1  125MHz core clock; the block's single clock.
- reset_in  in  1  synchronous, active-high reset.
- srcData_in  in  64*NUM_SRC  per-source TLP beat; source i occupies bits [64*i+63:64*i].
- srcValid_in  in  NUM_SRC  per-source beat valid.
- srcReady_out  out  NUM_SRC  per-source beat accepted when valid&ready.
- srcSOP_in  in  NUM_SRC  per-source first beat of TLP.
- srcEOP_in  in  NUM_SRC  per-source last beat of TLP.
- txData_out  out  64  to hard IP.
- txValid_out  out  1  to hard IP.
- txReady_in  in  1  from hard IP; ready latency 0.
- txSOP_out  out  1  to hard IP.
- txEOP_out  out  1  to hard IP.
- grant_out  out  SRC_BITS  index of current owner; valid while busy_out=1.
- busy_out  out  1  a packet is in flight.
- protoErr_out  out  1  sticky protocol-error flag.

Behaviour:
- FSM states:
  - IDLE: no owner.
  - BUSY: grant_r owns the TX port.
- Reset (reset_in=1 at a clock edge):
  - state=IDLE, rrPtr=0, grant_r=0, protoErr=0.
  - All outputs 0: srcReady_out, txValid_out, txSOP_out, txEOP_out, txData_out, grant_out, busy_out, protoErr_out.
  - Reset mid-packet abandons the packet: txValid drops the next cycle, no EOP is emitted. This is legal only under global reset.
- IDLE:
  - A source is eligible when srcValid_in[i] & srcSOP_in[i].
  - Choose the first eligible index scanning rrPtr, rrPtr+1, ... mod NUM_SRC.
  - If any is eligible: grant_r <= that index, state <= BUSY.
  - In IDLE: txValid_out=0 and srcReady_out=0.
  - Result: one-cycle arbitration bubble before every TLP.
- BUSY (combinational pass-through from source g=grant_r):
  - txData_out = srcData[g], txValid_out = srcValid[g], txSOP_out = srcSOP[g], txEOP_out = srcEOP[g].
  - srcReady_out[g] = txReady_in; all other srcReady_out bits are 0.
  - Source-to-TX latency is 0 cycles.
- Packet end:
  - On srcValid[g] & txReady_in & srcEOP[g]: state <= IDLE, rrPtr <= (g+1) mod NUM_SRC (explicit compare-and-wrap, not power-of-2 truncation).
  - Single-beat TLP (SOP and EOP on the same beat) ends the packet that cycle.
- Stalls:
  - srcValid[g]=0 mid-packet: txValid_out=0, grant held indefinitely.
  - txReady_in=0: hold; the source must keep its data stable (Avalon-ST).
- Protocol errors (protoErr sticky until reset):
  - In IDLE, any srcValid_in[i]=1 with srcSOP_in[i]=0 sets protoErr. That source is not granted.
  - In BUSY, an accepted beat from g with srcSOP=1 that is not the first beat of the grant sets protoErr. The beat is still forwarded.
- Non-granted sources may assert valid at any time; they see ready=0 and are not harmed.
- Fairness: with all NUM_SRC continuously requesting, grants cycle 0,1,2,0,... Each source waits at most NUM_SRC-1 packets.
- busy_out = (state==BUSY); grant_out = grant_r, held after IDLE return until the next grant.

Optional Feature:
- Macro: TLP_TX_ARB_PRIO0_EN.
- Defined: source 0 has strict priority. In IDLE, if source 0 is eligible it wins regardless of rrPtr; rrPtr is not updated after a source-0 packet. Remaining sources share round-robin. This lets completions bypass posted DMA writes.
- Undefined: pure round-robin across all sources as above.

Test Plan:
- Single source 1 sends a 3-beat TLP (data 0xA1,0xA2,0xA3), txReady_in=1 -> txValid_out first high 1 cycle after SOP is presented; tx sees the 3 beats with SOP on 0xA1, EOP on 0xA3; busy_out falls the cycle after EOP; grant_out=1.
- All 3 sources continuously offer 2-beat TLPs from reset -> grant order 0,1,2,0,1,2; one idle cycle between packets; no interleaving.
- Source 0 mid-packet, txReady_in low 4 cycles while source 2 asserts SOP -> source 0 data held stable on txData_out, srcReady_out=0b000 during the stall, source 2 granted only after source 0's EOP.
- Source 1 asserts valid without SOP in IDLE -> protoErr_out=1 the next cycle and stays 1; source 1 is never granted; reset_in clears it to 0.
- reset_in asserted during beat 2 of a 4-beat TLP -> next cycle txValid_out=0, busy_out=0, rrPtr=0; a new SOP from source 2 is then granted normally.
- With TLP_TX_ARB_PRIO0_EN: sources 0 and 1 continuously request -> every arbitration picks 0; without the macro, picks alternate 0,1.

Source files
------------

// File: rtl/tlp_tx_arbiter_if.sv
// TLP source/TX bundle shared by the producers, the arbiter and the hard IP TX side.
// master: arbiter view (drives ready back to sources and the TX stream).
// slave : environment view (drives source beats and TX ready).
interface tlp_tx_arbiter_if #(
  parameter int NUM_SRC = 3
) ();
  logic [64*NUM_SRC-1:0] srcData_in;
  logic [NUM_SRC-1:0]    srcValid_in;
  logic [NUM_SRC-1:0]    srcReady_out;
  logic [NUM_SRC-1:0]    srcSOP_in;
  logic [NUM_SRC-1:0]    srcEOP_in;
  logic [63:0]           txData_out;
  logic                  txValid_out;
  logic                  txReady_in;
  logic                  txSOP_out;
  logic                  txEOP_out;

  modport master (
    input  srcData_in, srcValid_in, srcSOP_in, srcEOP_in, txReady_in,
    output srcReady_out, txData_out, txValid_out, txSOP_out, txEOP_out
  );

  modport slave (
    output srcData_in, srcValid_in, srcSOP_in, srcEOP_in, txReady_in,
    input  srcReady_out, txData_out, txValid_out, txSOP_out, txEOP_out
  );
endinterface

// File: rtl/tlp_tx_arbiter.sv
// Packet-level arbiter sharing one PCIe TX stream between NUM_SRC TLP producers.
// A grant is taken in IDLE (one bubble cycle) and held from SOP to EOP, so TLPs
// never interleave. Default scheduling is round-robin.
// Optional: define TLP_TX_ARB_PRIO0_EN to give source 0 strict priority; the
// round-robin pointer is then left untouched by source-0 packets.
module tlp_tx_arbiter #(
  parameter int NUM_SRC  = 3,
  parameter int SRC_BITS = $clog2(NUM_SRC)
) (
  input  logic                pcieClk_in,
  input  logic                reset_in,
  tlp_tx_arbiter_if.master    bus,
  output logic [SRC_BITS-1:0] grant_out,
  output logic                busy_out,
  output logic                protoErr_out
);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t              state_reg, state_next;
  logic [SRC_BITS-1:0] grant_reg, grant_next;
  logic [SRC_BITS-1:0] rrPtr_reg, rrPtr_next;
  logic                protoErr_reg, protoErr_next;
  logic                firstBeat_reg, firstBeat_next;

  logic [63:0]         srcDataArr [NUM_SRC];
  logic [NUM_SRC-1:0]  eligible;
  logic [NUM_SRC-1:0]  noSopValid;
  logic                pickValid;
  logic [SRC_BITS-1:0] pickIdx;
  logic [SRC_BITS:0]   scanIdx;
  logic [SRC_BITS-1:0] ptrAfterGrant;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_SRC; gi++) begin : g_src
      assign srcDataArr[gi]        = bus.srcData_in[64*gi +: 64];
      assign eligible[gi]          = bus.srcValid_in[gi] & bus.srcSOP_in[gi];
      assign noSopValid[gi]        = bus.srcValid_in[gi] & ~bus.srcSOP_in[gi];
      assign bus.srcReady_out[gi]  = (state_reg == BUSY) && (grant_reg == SRC_BITS'(gi)) && bus.txReady_in;
    end
  endgenerate

  // Explicit compare-and-wrap so non-power-of-2 source counts rotate correctly.
  assign ptrAfterGrant = (grant_reg == SRC_BITS'(NUM_SRC-1)) ? '0 : grant_reg + SRC_BITS'(1);

  // Rotating scan starting at rrPtr; the lowest scan offset with an eligible source wins.
  always_comb begin
    pickValid = 1'b0;
    pickIdx   = '0;
    scanIdx   = '0;
    for (int k = NUM_SRC-1; k >= 0; k--) begin
      scanIdx = {1'b0, rrPtr_reg} + (SRC_BITS+1)'(k);
      if (scanIdx >= (SRC_BITS+1)'(NUM_SRC)) begin
        scanIdx = scanIdx - (SRC_BITS+1)'(NUM_SRC);
      end
      if (eligible[scanIdx[SRC_BITS-1:0]]) begin
        pickValid = 1'b1;
        pickIdx   = scanIdx[SRC_BITS-1:0];
      end
    end
`ifdef TLP_TX_ARB_PRIO0_EN
    if (eligible[0]) begin
      pickValid = 1'b1;
      pickIdx   = '0;
    end
`endif
  end

  // Next-state logic plus the combinational pass-through from the granted source.
  always_comb begin
    state_next      = state_reg;
    grant_next      = grant_reg;
    rrPtr_next      = rrPtr_reg;
    protoErr_next   = protoErr_reg;
    firstBeat_next  = firstBeat_reg;
    bus.txData_out  = '0;
    bus.txValid_out = 1'b0;
    bus.txSOP_out   = 1'b0;
    bus.txEOP_out   = 1'b0;
    case (state_reg)
      IDLE: begin
        // A valid beat without SOP while nobody owns the port is a framing error.
        if (|noSopValid) begin
          protoErr_next = 1'b1;
        end
        if (pickValid) begin
          grant_next     = pickIdx;
          state_next     = BUSY;
          firstBeat_next = 1'b1;
        end
      end
      BUSY: begin
        bus.txData_out  = srcDataArr[grant_reg];
        bus.txValid_out = bus.srcValid_in[grant_reg];
        bus.txSOP_out   = bus.srcSOP_in[grant_reg];
        bus.txEOP_out   = bus.srcEOP_in[grant_reg];
        if (bus.srcValid_in[grant_reg] && bus.txReady_in) begin
          firstBeat_next = 1'b0;
          // A second SOP inside one grant is still forwarded but flagged.
          if (bus.srcSOP_in[grant_reg] && !firstBeat_reg) begin
            protoErr_next = 1'b1;
          end
          if (bus.srcEOP_in[grant_reg]) begin
            state_next = IDLE;
`ifdef TLP_TX_ARB_PRIO0_EN
            if (grant_reg != '0) begin
              rrPtr_next = ptrAfterGrant;
            end
`else
            rrPtr_next = ptrAfterGrant;
`endif
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State register; reset abandons any packet in flight.
  always_ff @(posedge pcieClk_in) begin
    if (reset_in) begin
      state_reg     <= IDLE;
      grant_reg     <= '0;
      rrPtr_reg     <= '0;
      protoErr_reg  <= 1'b0;
      firstBeat_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      grant_reg     <= grant_next;
      rrPtr_reg     <= rrPtr_next;
      protoErr_reg  <= protoErr_next;
      firstBeat_reg <= firstBeat_next;
    end
  end

  assign grant_out    = grant_reg;
  assign busy_out     = (state_reg == BUSY);
  assign protoErr_out = protoErr_reg;

endmodule

// File: tb/tb_tlp_tx_arbiter.sv
// Randomized bench for tlp_tx_arbiter with a packet-level reference model.
// Honours TLP_TX_ARB_PRIO0_EN the same way the design does.
`timescale 1ns/1ps
module tb_tlp_tx_arbiter;
  localparam int N  = 3;
  localparam int SB = $clog2(N);

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  tlp_tx_arbiter_if #(.NUM_SRC(N)) bus ();
  logic [SB-1:0] grant;
  logic          busy;
  logic          perr;

  tlp_tx_arbiter #(.NUM_SRC(N), .SRC_BITS(SB)) dut (
    .pcieClk_in  (clk),
    .reset_in    (rst),
    .bus         (bus),
    .grant_out   (grant),
    .busy_out    (busy),
    .protoErr_out(perr)
  );

`ifdef TLP_TX_ARB_PRIO0_EN
  localparam bit PRIO = 1'b1;
`else
  localparam bit PRIO = 1'b0;
`endif

  int compared = 0;
  int mismatched = 0;

  // single comparison point
  task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // source drivers
  int          pktsLeft [N];
  int          pktLen   [N];
  int          beatIdx  [N];
  int          pktNum   [N];
  bit          presenting [N];
  logic [63:0] dataBase [N];
  int gapPct = 0, readyPct = 100, lenMin = 2, lenMax = 2;
  bit rogue1 = 1'b0, readyForceLow = 1'b0, rstReq = 1'b0;

  logic [N-1:0] vIn, sIn, eIn, acc;
  logic [63:0]  dIn [N];
  logic         rdy;

  // reference model: owner (-1 = none), round-robin start, last grant, sticky error
  int mOwner = -1, mPtr = 0, mLast = 0, mBeats = 0;
  bit mErr = 1'b0;

  int grantLog[$];
  bit prevBusy = 1'b0;

  function automatic int newLen();
    return int'($urandom_range(lenMax, lenMin));
  endfunction

  task automatic loadSrc(input int i, input int n);
    pktsLeft[i] = n;
    pktNum[i]   = 0;
    beatIdx[i]  = 0;
    pktLen[i]   = newLen();
  endtask

  task automatic driveInputs();
    rst = rstReq;
    for (int i = 0; i < N; i++) begin
      if (!presenting[i] && pktsLeft[i] > 0 && int'($urandom_range(99, 0)) >= gapPct)
        presenting[i] = 1'b1;
      vIn[i] = presenting[i];
      sIn[i] = presenting[i] && beatIdx[i] == 0;
      eIn[i] = presenting[i] && beatIdx[i] == pktLen[i] - 1;
      dIn[i] = presenting[i] ? dataBase[i] + 64'(pktNum[i] << 8) + 64'(beatIdx[i]) : 64'h0;
      if (i == 1 && rogue1 && !presenting[i]) begin
        vIn[i] = 1'b1;
        sIn[i] = 1'b0;
      end
      bus.srcData_in[64*i +: 64] = dIn[i];
    end
    rdy = !readyForceLow && int'($urandom_range(99, 0)) < readyPct;
    bus.srcValid_in = vIn;
    bus.srcSOP_in   = sIn;
    bus.srcEOP_in   = eIn;
    bus.txReady_in  = rdy;
  endtask

  task automatic checkOutputs();
    logic [63:0]  eData;
    logic         eV, eS, eE;
    logic [N-1:0] eR;
    eData = '0; eV = 0; eS = 0; eE = 0; eR = '0;
    if (mOwner >= 0) begin
      eData = dIn[mOwner];
      eV = vIn[mOwner];
      eS = sIn[mOwner];
      eE = eIn[mOwner];
      eR[mOwner] = rdy;
    end
    checkVal("txValid", 64'(bus.txValid_out), 64'(eV));
    checkVal("txSOP", 64'(bus.txSOP_out), 64'(eS));
    checkVal("txEOP", 64'(bus.txEOP_out), 64'(eE));
    checkVal("txData", bus.txData_out, eData);
    checkVal("srcReady", 64'(bus.srcReady_out), 64'(eR));
    checkVal("busy", 64'(busy), 64'(mOwner >= 0));
    checkVal("grant", 64'(grant), 64'(mLast));
    checkVal("protoErr", 64'(perr), 64'(mErr));
    acc = vIn & eR;
  endtask

  task automatic modelUpdate();
    int pick;
    if (rst) begin
      mOwner = -1; mPtr = 0; mLast = 0; mErr = 1'b0; mBeats = 0;
    end else if (mOwner < 0) begin
      pick = -1;
      for (int i = 0; i < N; i++)
        if (vIn[i] && !sIn[i]) mErr = 1'b1;
      if (PRIO && vIn[0] && sIn[0]) pick = 0;
      for (int k = 0; k < N; k++) begin
        int j;
        j = (mPtr + k) % N;
        if (pick < 0 && vIn[j] && sIn[j]) pick = j;
      end
      if (pick >= 0) begin
        mOwner = pick; mLast = pick; mBeats = 0;
      end
    end else if (vIn[mOwner] && rdy) begin
      if (sIn[mOwner] && mBeats > 0) mErr = 1'b1;
      mBeats++;
      if (eIn[mOwner]) begin
        $display("tlp done: src=%0d beats=%0d t=%0t", mOwner, mBeats, $time);
        if (!(PRIO && mOwner == 0)) mPtr = (mOwner + 1) % N;
        mOwner = -1;
      end
    end
  endtask

  task automatic driverUpdate();
    for (int i = 0; i < N; i++) begin
      if (rst) begin
        presenting[i] = 1'b0; beatIdx[i] = 0; pktsLeft[i] = 0;
      end else if (presenting[i] && acc[i]) begin
        presenting[i] = 1'b0;
        beatIdx[i]++;
        if (beatIdx[i] == pktLen[i]) begin
          beatIdx[i] = 0;
          pktsLeft[i]--;
          pktNum[i]++;
          pktLen[i] = newLen();
        end
      end
    end
  endtask

  task automatic step();
    @(negedge clk);
    driveInputs();
    #1;
    checkOutputs();
    if (busy && !prevBusy) grantLog.push_back(int'(grant));
    prevBusy = busy;
    @(posedge clk);
    modelUpdate();
    driverUpdate();
  endtask

  function automatic bit pending();
    for (int i = 0; i < N; i++)
      if (pktsLeft[i] > 0) return 1'b1;
    return mOwner >= 0;
  endfunction

  task automatic waitDrain(input string tag, input int maxCyc);
    int c;
    c = 0;
    while (pending() && c < maxCyc) begin
      step();
      c++;
    end
    checkVal(tag, 64'(c < maxCyc), 64'd1);
    step();
  endtask

  task automatic doReset();
    rstReq = 1'b1;
    step();
    rstReq = 1'b0;
    grantLog.delete();
  endtask

  task automatic checkOrder(input string tag, input int exp[]);
    checkVal({tag, "_count"}, 64'(grantLog.size()), 64'(exp.size()));
    for (int i = 0; i < exp.size() && i < grantLog.size(); i++)
      checkVal(tag, 64'(grantLog[i]), 64'(exp[i]));
  endtask

  initial begin
    int order[];
    for (int i = 0; i < N; i++) begin
      pktsLeft[i] = 0; pktLen[i] = 1; beatIdx[i] = 0; pktNum[i] = 0;
      presenting[i] = 1'b0; dataBase[i] = 64'(i) << 56;
    end
    bus.srcData_in = '0; bus.srcValid_in = '0; bus.srcSOP_in = '0;
    bus.srcEOP_in = '0; bus.txReady_in = 1'b0;
    repeat (2) @(posedge clk);
    step();
    step();

    // single 3-beat TLP from source 1
    dataBase[1] = 64'hA1;
    lenMin = 3; lenMax = 3;
    loadSrc(1, 1);
    waitDrain("t1_drain", 50);
    checkOrder("t1_grant", '{1});
    checkVal("t1_grant_held", 64'(grant), 64'd1);
    dataBase[1] = 64'(1) << 56;

    // all three sources, two 2-beat TLPs each
    doReset();
    lenMin = 2; lenMax = 2;
    for (int i = 0; i < N; i++) loadSrc(i, 2);
    waitDrain("t2_drain", 100);
    if (PRIO) order = '{0, 0, 1, 2, 1, 2};
    else      order = '{0, 1, 2, 0, 1, 2};
    checkOrder("t2_order", order);

    // stall source 0 mid-packet while source 2 waits with SOP
    doReset();
    lenMin = 4; lenMax = 4;
    loadSrc(0, 1);
    repeat (3) step();
    lenMin = 2; lenMax = 2;
    loadSrc(2, 1);
    readyForceLow = 1'b1;
    repeat (4) begin
      step();
      #1;
      checkVal("t3_hold_data", bus.txData_out, dataBase[0] + 64'd2);
      checkVal("t3_hold_ready", 64'(bus.srcReady_out), 64'd0);
      checkVal("t3_hold_grant", 64'(grant), 64'd0);
    end
    readyForceLow = 1'b0;
    waitDrain("t3_drain", 50);
    checkOrder("t3_order", '{0, 2});

    // valid without SOP in IDLE
    doReset();
    rogue1 = 1'b1;
    step();
    #1;
    checkVal("t4_err_set", 64'(perr), 64'd1);
    repeat (5) step();
    #1;
    checkVal("t4_err_sticky", 64'(perr), 64'd1);
    checkVal("t4_no_grant", 64'(busy), 64'd0);
    rogue1 = 1'b0;
    doReset();
    #1;
    checkVal("t4_err_clear", 64'(perr), 64'd0);

    // reset during beat 2 of a 4-beat TLP
    lenMin = 4; lenMax = 4;
    loadSrc(1, 1);
    repeat (2) step();
    rstReq = 1'b1;
    step();
    rstReq = 1'b0;
    #1;
    checkVal("t5_txValid", 64'(bus.txValid_out), 64'd0);
    checkVal("t5_busy", 64'(busy), 64'd0);
    grantLog.delete();
    lenMin = 2; lenMax = 2;
    loadSrc(2, 1);
    waitDrain("t5_drain", 50);
    checkOrder("t5_order", '{2});

    // sources 0 and 1 continuously requesting
    doReset();
    loadSrc(0, 3);
    loadSrc(1, 3);
    waitDrain("t6_drain", 100);
    if (PRIO) order = '{0, 0, 0, 1, 1, 1};
    else      order = '{0, 1, 0, 1, 0, 1};
    checkOrder("t6_order", order);

    // random traffic with gaps and TX backpressure
    doReset();
    gapPct = 30; readyPct = 70; lenMin = 1; lenMax = 5;
    for (int i = 0; i < N; i++) loadSrc(i, 15);
    waitDrain("rand_drain", 3000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
